// File: rtl/vga_pkg.sv
// Shared VGA definitions: the pattern mode encoding and helpers that derive
// line/frame totals and sync windows from the porch parameters.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    function automatic int line_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int vis, input int fp);
        return vis + fp;
    endfunction

    function automatic int sync_end(input int vis, input int fp, input int sync);
        return vis + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: pixel/line/frame counters plus combinational decode of the
// sync windows, the visible region and the top-left pixel of a frame.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS_AREA_PXL    = 32'sd800,
    parameter int H_FRONT_PORCH_PXL = 32'sd40,
    parameter int H_SYNC_PULSE_PXL  = 32'sd128,
    parameter int H_BACK_PORCH_PXL  = 32'sd88,
    parameter int H_NUM_BITS        = 32'sd11,
    parameter int V_VIS_AREA_PXL    = 32'sd600,
    parameter int V_FRONT_PORCH_PXL = 32'sd1,
    parameter int V_SYNC_PULSE_PXL  = 32'sd4,
    parameter int V_BACK_PORCH_PXL  = 32'sd23,
    parameter int V_NUM_BITS        = 32'sd10
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [H_NUM_BITS-1:0] h_cnt,
    output logic [V_NUM_BITS-1:0] v_cnt,
    output logic [7:0]            frame_cnt,
    output logic                  h_sync_act,
    output logic                  v_sync_act,
    output logic                  visible,
    output logic                  frame_first
);

    localparam int H_TOT_C = line_total(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL, H_SYNC_PULSE_PXL, H_BACK_PORCH_PXL);
    localparam int V_TOT_C = line_total(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL, V_SYNC_PULSE_PXL, V_BACK_PORCH_PXL);
    localparam int H_SS_C  = sync_start(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL);
    localparam int H_SE_C  = sync_end(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL, H_SYNC_PULSE_PXL);
    localparam int V_SS_C  = sync_start(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL);
    localparam int V_SE_C  = sync_end(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL, V_SYNC_PULSE_PXL);

    logic [H_NUM_BITS-1:0] h_cnt_r;
    logic [V_NUM_BITS-1:0] v_cnt_r;
    logic [7:0]            frame_cnt_r;
    logic [31:0]           h_pos_s;
    logic [31:0]           v_pos_s;
    logic                  h_wrap_s;
    logic                  v_wrap_s;

    // Positions widened to 32 bits so window bounds never overflow the counter width.
    assign h_pos_s  = 32'(h_cnt_r);
    assign v_pos_s  = 32'(v_cnt_r);
    assign h_wrap_s = (h_pos_s == 32'(H_TOT_C - 32'sd1));
    assign v_wrap_s = (v_pos_s == 32'(V_TOT_C - 32'sd1));

    // Advance pixel, line and frame counters in raster order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt_r     <= '0;
            v_cnt_r     <= '0;
            frame_cnt_r <= 8'd0;
        end else if (h_wrap_s) begin
            h_cnt_r <= '0;
            if (v_wrap_s) begin
                v_cnt_r     <= '0;
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                v_cnt_r <= v_cnt_r + V_NUM_BITS'(1'b1);
            end
        end else begin
            h_cnt_r <= h_cnt_r + H_NUM_BITS'(1'b1);
        end
    end

    assign h_cnt       = h_cnt_r;
    assign v_cnt       = v_cnt_r;
    assign frame_cnt   = frame_cnt_r;
    assign h_sync_act  = (h_pos_s >= 32'(H_SS_C)) && (h_pos_s < 32'(H_SE_C));
    assign v_sync_act  = (v_pos_s >= 32'(V_SS_C)) && (v_pos_s < 32'(V_SE_C));
    assign visible     = (h_pos_s < 32'(H_VIS_AREA_PXL)) && (v_pos_s < 32'(V_VIS_AREA_PXL));
    assign frame_first = (h_pos_s == 32'd0) && (v_pos_s == 32'd0);

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: solid colour, colour bars, checkerboard and scrolling
// gradient, with pixel data, syncs and frame marker registered together.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS_AREA_PXL    = 32'sd800,
    parameter int   H_FRONT_PORCH_PXL = 32'sd40,
    parameter int   H_SYNC_PULSE_PXL  = 32'sd128,
    parameter int   H_BACK_PORCH_PXL  = 32'sd88,
    parameter int   H_NUM_BITS        = 32'sd11,
    parameter int   V_VIS_AREA_PXL    = 32'sd600,
    parameter int   V_FRONT_PORCH_PXL = 32'sd1,
    parameter int   V_SYNC_PULSE_PXL  = 32'sd4,
    parameter int   V_BACK_PORCH_PXL  = 32'sd23,
    parameter int   V_NUM_BITS        = 32'sd10,
    parameter int   CHANNEL_BITS      = 32'sd4,
    parameter logic H_SYNC_POL        = 1'b1,
    parameter logic V_SYNC_POL        = 1'b1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [1:0]                mode,
    input  logic [3*CHANNEL_BITS-1:0] color,
    output logic [CHANNEL_BITS-1:0]   red,
    output logic [CHANNEL_BITS-1:0]   green,
    output logic [CHANNEL_BITS-1:0]   blue,
    output logic                      h_sync,
    output logic                      v_sync,
    output logic                      frame_start
);

    localparam int BAR_W_C = H_VIS_AREA_PXL / 32'sd8;
    localparam int CB      = CHANNEL_BITS;

    logic [H_NUM_BITS-1:0] h_cnt_s;
    logic [V_NUM_BITS-1:0] v_cnt_s;
    logic [7:0]            frame_cnt_s;
    logic                  h_sync_act_s;
    logic                  v_sync_act_s;
    logic                  visible_s;
    logic                  frame_first_s;
    logic [31:0]           h_pos_s;
    logic [31:0]           v_pos_s;
    logic                  cell_odd_s;
    logic [2:0]            bar_s;
    mode_e                 mode_r;
    mode_e                 mode_s;
    logic [3*CB-1:0]       color_r;
    logic [3*CB-1:0]       color_s;
    logic [3*CB-1:0]       pix_s;

    vga_timing #(
        .H_VIS_AREA_PXL    (H_VIS_AREA_PXL),
        .H_FRONT_PORCH_PXL (H_FRONT_PORCH_PXL),
        .H_SYNC_PULSE_PXL  (H_SYNC_PULSE_PXL),
        .H_BACK_PORCH_PXL  (H_BACK_PORCH_PXL),
        .H_NUM_BITS        (H_NUM_BITS),
        .V_VIS_AREA_PXL    (V_VIS_AREA_PXL),
        .V_FRONT_PORCH_PXL (V_FRONT_PORCH_PXL),
        .V_SYNC_PULSE_PXL  (V_SYNC_PULSE_PXL),
        .V_BACK_PORCH_PXL  (V_BACK_PORCH_PXL),
        .V_NUM_BITS        (V_NUM_BITS)
    ) u_timing (
        .clk         (clk),
        .resetn      (resetn),
        .h_cnt       (h_cnt_s),
        .v_cnt       (v_cnt_s),
        .frame_cnt   (frame_cnt_s),
        .h_sync_act  (h_sync_act_s),
        .v_sync_act  (v_sync_act_s),
        .visible     (visible_s),
        .frame_first (frame_first_s)
    );

    assign h_pos_s    = 32'(h_cnt_s);
    assign v_pos_s    = 32'(v_cnt_s);
    assign cell_odd_s = ((h_pos_s & 32'd32) != (v_pos_s & 32'd32));

    // Capture the pattern selection once per frame, at the top-left pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_r  <= MODE_SOLID;
            color_r <= '0;
        end else if (frame_first_s) begin
            mode_r  <= mode_s;
            color_r <= color_s;
        end else begin
            mode_r  <= mode_r;
            color_r <= color_r;
        end
    end

    // The top-left pixel already renders with the selection being captured.
    always_comb begin
        mode_s  = mode_r;
        color_s = color_r;
        if (frame_first_s) begin
            mode_s  = mode_e'(mode);
            color_s = color;
        end else begin
            mode_s  = mode_r;
            color_s = color_r;
        end
    end

    // Pixel colour for the current raster position; blanking forces black.
    always_comb begin
        bar_s = 3'd0;
        pix_s = '0;
        for (int b = 1; b < 8; b++) begin
            bar_s = (h_pos_s >= 32'(b * BAR_W_C)) ? 3'(b) : bar_s;
        end
        if (visible_s) begin
            case (mode_s)
                MODE_SOLID:    pix_s = color_s;
                MODE_BARS:     pix_s = {{CB{bar_s[2]}}, {CB{bar_s[1]}}, {CB{bar_s[0]}}};
                MODE_CHECKER:  pix_s = cell_odd_s ? ~color_s : color_s;
                // Gradient sum wraps at the counter width so the ramp scrolls.
                MODE_GRADIENT: pix_s = {CB'((h_cnt_s + H_NUM_BITS'(frame_cnt_s)) >> (H_NUM_BITS - CB)),
                                        v_cnt_s[V_NUM_BITS-1 -: CB],
                                        color_s[CB-1:0]};
                default:       pix_s = '0;
            endcase
        end else begin
            pix_s = '0;
        end
    end

    // Register pixel data and keep syncs and the frame marker aligned with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            h_sync      <= ~H_SYNC_POL;
            v_sync      <= ~V_SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            red         <= pix_s[3*CB-1 -: CB];
            green       <= pix_s[2*CB-1 -: CB];
            blue        <= pix_s[CB-1:0];
            h_sync      <= h_sync_act_s ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync      <= v_sync_act_s ? V_SYNC_POL : ~V_SYNC_POL;
            frame_start <= frame_first_s & visible_s;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a reduced raster so that long
// multi-frame behaviour (frame counter wrap) fits in a short run.
module tb_vga_pattern_gen;

    localparam int HV = 34, HF = 2, HS = 2, HB = 2, HT = 40, HN = 9;
    localparam int VV = 3,  VF = 1, VS = 1, VB = 1, VT = 6,  VN = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } out_t;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] color;
        int          x;
        int          y;
        logic [11:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] color = 12'h000;
    logic [3:0]  red, green, blue;
    logic        h_sync, v_sync, frame_start;

    out_t sb_q[$];
    out_t got;
    int   vectors = 0;
    int   miscompares = 0;
    int   mh = 0, mv = 0, mfc = 0;
    logic [1:0]  lm = 2'd0;
    logic [11:0] lc = 12'h000;
    int   last_h = 0, last_v = 0;
    int   frames_seen = 0;
    vec_t tbl[12];

    vga_pattern_gen #(
        .H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HS), .H_BACK_PORCH_PXL(HB),
        .H_NUM_BITS(HN),
        .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VS), .V_BACK_PORCH_PXL(VB),
        .V_NUM_BITS(VN),
        .CHANNEL_BITS(4), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn), .mode(mode), .color(color),
        .red(red), .green(green), .blue(blue),
        .h_sync(h_sync), .v_sync(v_sync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic out_t model(input int h, input int v, input int fc,
                                   input logic [1:0] md, input logic [11:0] c);
        out_t o;
        int   bar;
        int   s;
        o    = '0;
        o.hs = (h >= HV + HF) && (h < HV + HF + HS);
        o.vs = (v >= VV + VF) && (v < VV + VF + VS);
        o.fs = (h == 0) && (v == 0);
        if (h < HV && v < VV) begin
            case (md)
                2'd0: {o.r, o.g, o.b} = c;
                2'd1: begin
                    bar = h / (HV / 8);
                    if (bar > 7) bar = 7;
                    o.r = bar[2] ? 4'hF : 4'h0;
                    o.g = bar[1] ? 4'hF : 4'h0;
                    o.b = bar[0] ? 4'hF : 4'h0;
                end
                2'd2: {o.r, o.g, o.b} = ((((h / 32) + (v / 32)) % 2) == 1) ? ~c : c;
                default: begin
                    s   = (h + fc) % 512;
                    o.r = 4'(s / 32);
                    o.g = 4'(v);
                    o.b = c[3:0];
                end
            endcase
        end
        return o;
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock: predict the output for the current raster state, then compare.
    task automatic step();
        out_t e;
        int   ch, cv;
        ch = mh;
        cv = mv;
        if (!resetn) begin
            e = '0;
            mh = 0; mv = 0; mfc = 0; lm = 2'd0; lc = 12'h000; frames_seen = 0;
        end else begin
            if (mh == 0 && mv == 0) begin
                lm = mode;
                lc = color;
                frames_seen++;
            end
            e = model(mh, mv, mfc, lm, lc);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) begin
                    mv = 0;
                    mfc = (mfc + 1) % 256;
                end
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {red, green, blue, h_sync, v_sync, frame_start};
        e = sb_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL scoreboard at h=%0d v=%0d: got rgb=%h hs=%b vs=%b fs=%b, required rgb=%h hs=%b vs=%b fs=%b",
                     ch, cv, {got.r, got.g, got.b}, got.hs, got.vs, got.fs,
                     {e.r, e.g, e.b}, e.hs, e.vs, e.fs);
        end
        last_h = ch;
        last_v = cv;
    endtask

    task automatic wait_coord(input int x, input int y);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * HT * VT + 4 && !hit; k++) begin
            step();
            hit = (last_h == x) && (last_v == y);
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_coord: got no output for (%0d,%0d), required one within budget", x, y);
        end
    endtask

    initial begin
        int hr1, hr2, hw, vr1, vr2, vw;
        logic phs, pvs;

        tbl[0]  = '{2'd0, 12'hF0A, 0,  0, 12'hF0A};
        tbl[1]  = '{2'd0, 12'hF0A, 33, 2, 12'hF0A};
        tbl[2]  = '{2'd0, 12'hF0A, 34, 0, 12'h000};
        tbl[3]  = '{2'd0, 12'hF0A, 5,  3, 12'h000};
        tbl[4]  = '{2'd1, 12'h000, 0,  0, 12'h000};
        tbl[5]  = '{2'd1, 12'h000, 4,  1, 12'h00F};
        tbl[6]  = '{2'd1, 12'h000, 8,  0, 12'h0F0};
        tbl[7]  = '{2'd1, 12'h000, 20, 0, 12'hF0F};
        tbl[8]  = '{2'd1, 12'h000, 29, 0, 12'hFFF};
        tbl[9]  = '{2'd1, 12'h000, 33, 2, 12'hFFF};
        tbl[10] = '{2'd2, 12'h5A3, 0,  0, 12'h5A3};
        tbl[11] = '{2'd2, 12'h5A3, 32, 0, 12'hA5C};

        // Reset state.
        for (int i = 0; i < 3; i++) step();
        mode = 2'd0;
        color = 12'hF0A;
        resetn = 1'b1;

        // Table-driven pixel checks, one frame per record.
        for (int i = 0; i < 12; i++) begin
            mode  = tbl[i].mode;
            color = tbl[i].color;
            wait_coord(0, 0);
            wait_coord(tbl[i].x, tbl[i].y);
            check_val($sformatf("pixel_tbl%0d", i), {red, green, blue}, tbl[i].rgb);
        end

        // Mode change mid-frame only takes effect at the next frame.
        mode = 2'd0; color = 12'hF0A;
        wait_coord(0, 0);
        wait_coord(10, 1);
        mode = 2'd2;
        wait_coord(32, 2);
        check_val("midframe_hold", {red, green, blue}, 12'hF0A);
        wait_coord(0, 0);
        check_val("new_frame_fs", frame_start, 1);
        wait_coord(32, 0);
        check_val("checker_inverse", {red, green, blue}, 12'h0F5);

        // Sync period and width measurement over three frames.
        hr1 = -1; hr2 = -1; hw = 0; vr1 = -1; vr2 = -1; vw = 0;
        phs = h_sync; pvs = v_sync;
        for (int k = 0; k < 3 * HT * VT; k++) begin
            step();
            if (got.hs && !phs) begin
                if (hr1 < 0) hr1 = k; else if (hr2 < 0) hr2 = k;
            end
            if (got.vs && !pvs) begin
                if (vr1 < 0) vr1 = k; else if (vr2 < 0) vr2 = k;
            end
            if (got.hs && hr1 >= 0 && hr2 < 0) hw++;
            if (got.vs && vr1 >= 0 && vr2 < 0) vw++;
            phs = got.hs;
            pvs = got.vs;
        end
        check_val("hsync_period", hr2 - hr1, HT);
        check_val("hsync_width", hw, HS);
        check_val("vsync_period", vr2 - vr1, HT * VT);
        check_val("vsync_width", vw, HT * VS);

        // Asynchronous reset during an active sync pulse.
        mode = 2'd0; color = 12'hF0A;
        wait_coord(0, 0);
        wait_coord(HV + HF, VV + VF);
        check_val("pre_reset_hsync", h_sync, 1);
        check_val("pre_reset_vsync", v_sync, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_val("async_reset_outputs", {red, green, blue, h_sync, v_sync, frame_start}, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        check_val("restart_fs", frame_start, 1);
        check_val("restart_red", red, 4'hF);
        step();
        check_val("restart_fs_pulse", frame_start, 0);

        // Gradient over 258 frames: red at x=0 tracks the 8-bit frame counter.
        mode = 2'd3; color = 12'h123;
        for (int f = 0; f < 258; f++) begin
            wait_coord(0, 0);
            check_val($sformatf("gradient_f%0d", f), red, ((frames_seen - 1) % 256) / 32);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
